tawas_dbus_arb: RTL and testbench
=================================

Name: tawas_dbus_arb

Overview:
- Shares one single-ported synchronous data RAM between the Tawas core load/store port (master 0) and a secondary bus master (master 1, e.g. debug/DMA).
- The core has absolute priority and is never stalled: its fixed read timing (RAM data valid RD_LAT cycles after DCS) must be preserved.
- The secondary master gets idle cycles through a REQ/ACK handshake.
- The block tracks in-flight secondary reads, returns their data with a valid pulse, and flags secondary starvation.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from the DCS cycle to the cycle MEM_DIN is valid (1..4).
- STARVE_MAX, 64, consecutive unserved S_REQ cycles before S_STARVE asserts (2..65535).

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- C_DADDR  in  32  core word address (bits [1:0] zero)
- C_DCS  in  1  core access valid this cycle
- C_DWR  in  1  core write (1) / read (0)
- C_DMASK  in  4  core byte enables
- C_DOUT  in  32  core write data
- C_DIN  out  32  core read data, equal to MEM_DIN (combinational)
- S_REQ  in  1  secondary request; held with fields stable until S_ACK
- S_WR  in  1  secondary write (1) / read (0)
- S_ADDR  in  32  secondary byte address; [1:0] ignored
- S_MASK  in  4  secondary byte enables
- S_WDATA  in  32  secondary write data
- S_ACK  out  1  request accepted this cycle (combinational)
- S_RVLD  out  1  secondary read data valid pulse
- S_RDATA  out  32  secondary read data, valid when S_RVLD
- S_STARVE  out  1  secondary starved indication
- MEM_ADDR  out  32  RAM address
- MEM_CS  out  1  RAM select
- MEM_WR  out  1  RAM write
- MEM_MASK  out  4  RAM byte enables
- MEM_DOUT  out  32  RAM write data
- MEM_DIN  in  32  RAM read data

Behaviour:
- Arbitration is combinational, with no added latency on the core path.
  - C_DCS=1: MEM_* = core fields; S_ACK=0.
  - C_DCS=0 and S_REQ=1: MEM_ADDR={S_ADDR[31:2],2'b00}, MEM_CS=1, MEM_WR=S_WR, MEM_MASK=S_MASK; S_ACK=1.
  - Neither: MEM_CS=0 and MEM_WR=0; MEM_ADDR, MEM_MASK and MEM_DOUT are all zero.
- MEM_DOUT is the write data of the granted master when its WR=1, else 0.
- C_DIN = MEM_DIN at all times. The core qualifies it with its own pipeline; the arbiter does not gate it.
- Read-return tracking uses an RD_LAT-deep shift register.
  - Stage 0 is loaded with (S_ACK && !S_WR) each cycle; all stages shift every cycle.
  - When the final stage is 1: S_RVLD=1 and S_RDATA=MEM_DIN, both registered on the edge ending that MEM_DIN-valid cycle, so S_RVLD appears RD_LAT+1 cycles after the S_ACK cycle.
  - Otherwise S_RVLD=0 and S_RDATA holds its last value.
- Back-to-back secondary reads are supported: one accept per cycle, in-order returns, no limit on outstanding reads.
- Secondary writes produce no S_RVLD.
- Starvation counter, 16 bits:
  - Cleared when S_REQ=0 or S_ACK=1.
  - Increments when S_REQ=1 and S_ACK=0; saturates at STARVE_MAX.
  - S_STARVE is registered: 1 while the counter equals STARVE_MAX, cleared the cycle after the next S_ACK or S_REQ deassertion.
  - S_STARVE is a status flag only; it does not override core priority.
- Secondary dropping S_REQ before S_ACK is a protocol violation. The arbiter simply stops serving it; no state is corrupted.
- Simultaneous C_DCS and S_REQ: the core wins, and the secondary waits with no lost request.
- Reset (RST_N low, asynchronous): read shift register, starvation counter, S_RVLD, S_RDATA and S_STARVE all go to 0.
  - Combinational outputs follow their inputs during reset, except that S_ACK is forced to 0 and MEM_CS is driven only by C_DCS.
  - Reads in flight at reset are discarded, and no S_RVLD is produced after reset release.

Test Plan:
- Core-only traffic: C_DCS read at 0x100, MEM_DIN=0xDEADBEEF next cycle -> MEM_ADDR=0x100, MEM_CS=1 same cycle, C_DIN=0xDEADBEEF, S_ACK never asserts.
- Secondary read, core idle, RD_LAT=1: S_REQ read at 0x00000206 -> same cycle MEM_ADDR=0x204, S_ACK=1; MEM_DIN=0x12345678 next cycle -> S_RVLD=1 with S_RDATA=0x12345678 RD_LAT+1 cycles after ACK.
- Collision: C_DCS=1 for 3 cycles while S_REQ is held with a write to 0x40, data 0xA5A5A5A5, mask 4'b0011 -> S_ACK=0 for 3 cycles, then S_ACK=1 with MEM_WR=1, MEM_MASK=0011, MEM_DOUT=0xA5A5A5A5, and no S_RVLD.
- Starvation, STARVE_MAX=4: C_DCS held high with S_REQ high -> S_STARVE rises after the 4th waiting cycle, then clears one cycle after C_DCS drops and S_ACK fires.
- Pipelined reads, RD_LAT=3: four back-to-back secondary reads in idle cycles -> four consecutive S_RVLD pulses, in order, with matching data.
- Reset mid-flight: RST_N low one cycle after a secondary read ACK -> S_RVLD, S_STARVE and the counter go to 0 immediately; no late S_RVLD after release.

Source files
------------

// File: rtl/tawas_dbus_arb.sv
// Data-RAM arbiter for the Tawas core (absolute priority) and a secondary bus master.
// Tracks secondary read returns through a latency-matched shift register and flags starvation.
module tawas_dbus_arb #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] C_DADDR,
  input  logic        C_DCS,
  input  logic        C_DWR,
  input  logic [3:0]  C_DMASK,
  input  logic [31:0] C_DOUT,
  output logic [31:0] C_DIN,
  input  logic        S_REQ,
  input  logic        S_WR,
  input  logic [31:0] S_ADDR,
  input  logic [3:0]  S_MASK,
  input  logic [31:0] S_WDATA,
  output logic        S_ACK,
  output logic        S_RVLD,
  output logic [31:0] S_RDATA,
  output logic        S_STARVE,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_CS,
  output logic        MEM_WR,
  output logic [3:0]  MEM_MASK,
  output logic [31:0] MEM_DOUT,
  input  logic [31:0] MEM_DIN
);

  localparam logic [15:0] LP_STARVE_MAX = 16'(STARVE_MAX);

  logic              w_sec_gnt;
  logic              w_unused;
  logic [15:0]       w_cnt_nxt;
  logic [RD_LAT-1:0] r_rd_sr;
  logic [15:0]       r_starve_cnt;
  logic              r_rvld;
  logic [31:0]       r_rdata;
  logic              r_starve;

  // Secondary is granted only in core-idle cycles and never while reset is held.
  assign w_sec_gnt = RST_N & ~C_DCS & S_REQ;
  assign w_unused  = ^S_ADDR[1:0];

  assign S_ACK    = w_sec_gnt;
  assign C_DIN    = MEM_DIN;
  assign S_RVLD   = r_rvld;
  assign S_RDATA  = r_rdata;
  assign S_STARVE = r_starve;

  always_comb begin
    MEM_ADDR = 32'h0;
    MEM_CS   = 1'b0;
    MEM_WR   = 1'b0;
    MEM_MASK = 4'h0;
    MEM_DOUT = 32'h0;
    if (C_DCS) begin
      MEM_ADDR = C_DADDR;
      MEM_CS   = 1'b1;
      MEM_WR   = C_DWR;
      MEM_MASK = C_DMASK;
      MEM_DOUT = C_DWR ? C_DOUT : 32'h0;
    end else if (w_sec_gnt) begin
      MEM_ADDR = {S_ADDR[31:2], 2'b00};
      MEM_CS   = 1'b1;
      MEM_WR   = S_WR;
      MEM_MASK = S_MASK;
      MEM_DOUT = S_WR ? S_WDATA : 32'h0;
    end
  end

  // Each bit marks an accepted secondary read; the last stage lines up with its RAM data cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_sr <= '0;
    end else begin
      r_rd_sr[0] <= w_sec_gnt & ~S_WR;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_sr[i] <= r_rd_sr[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rvld  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_rvld <= r_rd_sr[RD_LAT-1];
      if (r_rd_sr[RD_LAT-1]) begin
        r_rdata <= MEM_DIN;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (!S_REQ || w_sec_gnt) begin
      w_cnt_nxt = 16'h0;
    end else if (r_starve_cnt != LP_STARVE_MAX) begin
      w_cnt_nxt = r_starve_cnt + 16'h1;
    end
  end

  // The flag is registered from the next count so it tracks the counter without extra lag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_starve_cnt <= 16'h0;
      r_starve     <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_nxt;
      r_starve     <= (w_cnt_nxt == LP_STARVE_MAX);
    end
  end

endmodule

// File: tb/tb_tawas_dbus_arb.sv
// Randomized scoreboard bench for tawas_dbus_arb: expected read returns are queued at
// acceptance time and popped by an independent monitor on every S_RVLD.
module tb_tawas_dbus_arb;

  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] C_DADDR, C_DOUT, C_DIN, S_ADDR, S_WDATA, S_RDATA;
  logic [31:0] MEM_ADDR, MEM_DOUT, MEM_DIN;
  logic        C_DCS, C_DWR, S_REQ, S_WR, S_ACK, S_RVLD, S_STARVE, MEM_CS, MEM_WR;
  logic [3:0]  C_DMASK, S_MASK, MEM_MASK;

  tawas_dbus_arb #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .C_DADDR(C_DADDR), .C_DCS(C_DCS), .C_DWR(C_DWR), .C_DMASK(C_DMASK),
    .C_DOUT(C_DOUT), .C_DIN(C_DIN),
    .S_REQ(S_REQ), .S_WR(S_WR), .S_ADDR(S_ADDR), .S_MASK(S_MASK),
    .S_WDATA(S_WDATA), .S_ACK(S_ACK), .S_RVLD(S_RVLD), .S_RDATA(S_RDATA),
    .S_STARVE(S_STARVE),
    .MEM_ADDR(MEM_ADDR), .MEM_CS(MEM_CS), .MEM_WR(MEM_WR), .MEM_MASK(MEM_MASK),
    .MEM_DOUT(MEM_DOUT), .MEM_DIN(MEM_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rd_t;

  rd_t         q[$];
  int unsigned cyc = 0;
  int          run = 0;
  logic        exp_ack = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  // RAM contents are irrelevant; what it returns in any cycle is a fixed function of the cycle.
  function automatic logic [31:0] din_of(input int unsigned c);
    return (c * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic commit();
    exp_ack = RST_N && !C_DCS && S_REQ;
    if (exp_ack && !S_WR)
      q.push_back('{due: cyc + RD_LAT + 1, data: din_of(cyc + RD_LAT)});
  endtask

  task automatic cyc_drive(input logic dcs, input logic dwr, input logic [31:0] daddr,
                           input logic [3:0] dmask, input logic [31:0] dout,
                           input logic req, input logic swr, input logic [31:0] saddr,
                           input logic [3:0] smask, input logic [31:0] swd);
    @(posedge CLK);
    if (RST_N && S_REQ && !exp_ack) run++;
    else run = 0;
    cyc++;
    #1;
    C_DCS = dcs; C_DWR = dwr; C_DADDR = daddr; C_DMASK = dmask; C_DOUT = dout;
    S_REQ = req; S_WR = swr; S_ADDR = saddr; S_MASK = smask; S_WDATA = swd;
    MEM_DIN = din_of(cyc);
    commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_now();
    #2;
    RST_N = 1'b0;
    q.delete();
    run = 0;
    last_rdata = 32'h0;
    commit();
  endtask

  task automatic release_now();
    #2;
    RST_N = 1'b1;
    commit();
  endtask

  always @(negedge CLK) begin
    logic        e_cs, e_wr;
    logic [31:0] e_addr, e_dout;
    logic [3:0]  e_mask;
    rd_t         e;
    e_cs = 0; e_wr = 0; e_addr = 0; e_dout = 0; e_mask = 0;
    if (C_DCS) begin
      e_cs = 1; e_wr = C_DWR; e_addr = C_DADDR; e_mask = C_DMASK;
      e_dout = C_DWR ? C_DOUT : 32'h0;
    end else if (RST_N && S_REQ) begin
      e_cs = 1; e_wr = S_WR; e_addr = S_ADDR & 32'hFFFF_FFFC; e_mask = S_MASK;
      e_dout = S_WR ? S_WDATA : 32'h0;
    end
    chk("s_ack", S_ACK, exp_ack);
    chk("mem_cs", MEM_CS, e_cs);
    chk("mem_wr", MEM_WR, e_wr);
    chk("mem_addr", MEM_ADDR, e_addr);
    chk("mem_mask", MEM_MASK, e_mask);
    chk("mem_dout", MEM_DOUT, e_dout);
    chk("c_din", C_DIN, MEM_DIN);
    chk("s_starve", S_STARVE, (run >= STARVE_MAX));
    if (S_RVLD) begin
      if (q.size() == 0) begin
        chk("rvld_spurious", S_RVLD, 1'b0);
      end else begin
        e = q.pop_front();
        chk("rvld_cycle", cyc, e.due);
        chk("s_rdata", S_RDATA, e.data);
        last_rdata = e.data;
      end
    end else begin
      chk("rdata_hold", S_RDATA, last_rdata);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("rvld_missing", S_RVLD, 1'b1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic        r_req, r_wr, dcs, dwr;
    logic [31:0] r_addr, r_wd;
    logic [3:0]  r_mask;
    RST_N = 0; C_DCS = 0; C_DWR = 0; C_DADDR = 0; C_DMASK = 0; C_DOUT = 0;
    S_REQ = 0; S_WR = 0; S_ADDR = 0; S_MASK = 0; S_WDATA = 0; MEM_DIN = 0;
    idle(3);
    release_now();
    idle(2);

    // core read, then secondary read at an unaligned byte address
    cyc_drive(1, 0, 32'h100, 4'hF, 32'h0, 0, 0, 0, 0, 0);
    idle(2);
    cyc_drive(0, 0, 0, 0, 0, 1, 0, 32'h0000_0206, 4'hF, 0);
    idle(RD_LAT + 2);

    // collision: secondary write waits three core cycles
    for (int i = 0; i < 3; i++)
      cyc_drive(1, 1, 32'h80, 4'hF, 32'h1111_2222, 1, 1, 32'h40, 4'b0011, 32'hA5A5_A5A5);
    cyc_drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 4'b0011, 32'hA5A5_A5A5);
    idle(RD_LAT + 2);

    // starvation then release
    for (int i = 0; i < 6; i++)
      cyc_drive(1, 0, 32'h200, 4'hF, 0, 1, 0, 32'h300, 4'hF, 0);
    cyc_drive(0, 0, 0, 0, 0, 1, 0, 32'h300, 4'hF, 0);
    idle(RD_LAT + 3);

    // four back-to-back secondary reads
    for (int i = 0; i < 4; i++)
      cyc_drive(0, 0, 0, 0, 0, 1, 0, 32'h10 + 32'(i * 4), 4'hF, 0);
    idle(RD_LAT + 4);

    // reset one cycle after a read is accepted
    cyc_drive(0, 0, 0, 0, 0, 1, 0, 32'h500, 4'hF, 0);
    idle(1);
    reset_now();
    idle(2);
    release_now();
    idle(RD_LAT + 4);

    // reset while starved
    for (int i = 0; i < STARVE_MAX + 2; i++)
      cyc_drive(1, 0, 32'h600, 4'hF, 0, 1, 1, 32'h700, 4'hF, 32'h77);
    reset_now();
    idle(2);
    release_now();
    idle(3);

    r_req = 0; r_wr = 0; r_addr = 0; r_wd = 0; r_mask = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!r_req || exp_ack) begin
        r_req  = ($urandom_range(0, 3) != 0);
        r_wr   = $urandom_range(0, 1) == 1;
        r_addr = $urandom;
        r_mask = 4'($urandom);
        r_wd   = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        r_req = 0;
      end
      dcs = ($urandom_range(0, 9) < 6);
      dwr = $urandom_range(0, 1) == 1;
      cyc_drive(dcs, dwr, $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom,
                r_req, r_wr, r_addr, r_mask, r_wd);
    end
    idle(RD_LAT + 4);
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
